// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite address generator.
// Sprite geometry and coordinate/address widths live here so every block agrees.
package sprite_pkg;

  localparam int COORD_W   = 10;
  localparam int SPR_W     = 30;
  localparam int SPR_H     = 40;
  localparam int ADDR_W    = 14;
  localparam int SPR_DEPTH = SPR_W * SPR_H;
  localparam int OFF_W     = 6;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [COORD_W:0] sdelta_t;
  typedef logic [ADDR_W-1:0]       rom_addr_t;
  typedef logic [OFF_W-1:0]        off_t;

endpackage

// File: rtl/sprite_addr_gen_if.sv
// Pixel-in / ROM-address-out bundle between the VGA timing side and sprite_addr_gen.
// master drives coordinates and sprite position; slave returns the aligned address.
interface sprite_addr_gen_if;
  import sprite_pkg::*;

  logic      frame_start;
  logic      pix_valid;
  coord_t    col;
  coord_t    row;
  coord_t    pos_x;
  coord_t    pos_y;
  logic      facing_left;
  rom_addr_t addr;
  logic      in_sprite;
  logic      out_valid;

  modport master (
    output frame_start, pix_valid, col, row, pos_x, pos_y, facing_left,
    input  addr, in_sprite, out_valid
  );

  modport slave (
    input  frame_start, pix_valid, col, row, pos_x, pos_y, facing_left,
    output addr, in_sprite, out_valid
  );

endinterface

// File: rtl/sprite_box_check.sv
// Combinational offset of the current pixel from the sprite's top-left corner,
// plus the inside-the-box test that gates the ROM address.
module sprite_box_check
  import sprite_pkg::*;
(
  input  coord_t col,
  input  coord_t row,
  input  coord_t lat_x,
  input  coord_t lat_y,
  input  logic   pix_valid,
  output off_t   dx,
  output off_t   dy,
  output logic   box
);

  sdelta_t dx_full;
  sdelta_t dy_full;
  logic    dx_in;
  logic    dy_in;

  // Zero-extended subtraction: a pixel left of/above the sprite goes negative
  // instead of wrapping, so a sprite near the right edge never reappears on the left.
  assign dx_full = sdelta_t'({1'b0, col}) - sdelta_t'({1'b0, lat_x});
  assign dy_full = sdelta_t'({1'b0, row}) - sdelta_t'({1'b0, lat_y});

  assign dx_in = !dx_full[COORD_W] && (dx_full[COORD_W-1:0] < COORD_W'(SPR_W));
  assign dy_in = !dy_full[COORD_W] && (dy_full[COORD_W-1:0] < COORD_W'(SPR_H));

  assign box = pix_valid && dx_in && dy_in;
  assign dx  = dx_full[OFF_W-1:0];
  assign dy  = dy_full[OFF_W-1:0];

endmodule

// File: rtl/sprite_addr_gen.sv
// Two-stage sprite ROM address generator with per-frame position latch.
// Optional horizontal mirroring is enabled by defining SPRITE_HFLIP_EN.
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  sprite_addr_gen_if.slave  bus
);

  coord_t    lat_x;
  coord_t    lat_y;
  logic      lat_flip;

  off_t      box_dx;
  off_t      box_dy;
  logic      box_hit;

  off_t      s1_dx;
  off_t      s1_dy;
  logic      s1_box;
  logic      s1_valid;

  off_t      col_off;
  rom_addr_t next_addr;

  rom_addr_t addr_q;
  logic      in_sprite_q;
  logic      out_valid_q;

  // Position only moves at frame_start so a sprite never tears mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_x    <= '0;
      lat_y    <= '0;
      lat_flip <= 1'b0;
    end else if (bus.frame_start) begin
      lat_x    <= bus.pos_x;
      lat_y    <= bus.pos_y;
      lat_flip <= bus.facing_left;
    end
  end

  sprite_box_check u_box_check (
    .col       (bus.col),
    .row       (bus.row),
    .lat_x     (lat_x),
    .lat_y     (lat_y),
    .pix_valid (bus.pix_valid),
    .dx        (box_dx),
    .dy        (box_dy),
    .box       (box_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_box   <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_dx    <= box_dx;
      s1_dy    <= box_dy;
      s1_box   <= box_hit;
      s1_valid <= bus.pix_valid;
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic s1_flip;

  // Flip travels with its pixel so a frame_start-coincident pixel keeps the old facing.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_flip <= 1'b0;
    end else begin
      s1_flip <= lat_flip;
    end
  end

  always_comb begin
    col_off = s1_dx;
    if (s1_flip) begin
      col_off = off_t'(SPR_W - 1) - s1_dx;
    end
  end
`else
  logic unused_flip;

  assign unused_flip = lat_flip;

  always_comb begin
    col_off = s1_dx;
  end
`endif

  assign next_addr = rom_addr_t'(s1_dy) * rom_addr_t'(SPR_W) + rom_addr_t'(col_off);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      in_sprite_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      addr_q      <= s1_box ? next_addr : '0;
      in_sprite_q <= s1_box;
      out_valid_q <= s1_valid;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.in_sprite = in_sprite_q;
  assign bus.out_valid = out_valid_q;

endmodule
